// File: rtl/hazard_pkg.sv
// Shared constants, FSM encoding and forwarding-select helper for the hazard unit.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [3:0] PC_IDX = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Memory stage wins over writeback; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       rw_m,
    input logic [3:0] wa_m,
    input logic       rw_w,
    input logic [3:0] wa_w
  );
    if (ra == PC_IDX)           return FWD_NONE;
    if (rw_m && (ra == wa_m))   return FWD_M;
    if (rw_w && (ra == wa_w))   return FWD_W;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard interface between the control cell (master) and the hazard unit (slave).
interface hazard_if;
  logic [3:0] RA1D, RA2D, RA3D;
  logic       R3D_valid;
  logic [3:0] RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       MemtoRegE, RegWriteM, RegWriteW;
  logic       Mul_CtrlD, PCWrPendingF, PCSrcW, BranchTakenE;

  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       MulBusy;

  modport master (
    output RA1D, RA2D, RA3D, R3D_valid, RA1E, RA2E, WA3E, WA3M, WA3W,
           MemtoRegE, RegWriteM, RegWriteW, Mul_CtrlD, PCWrPendingF, PCSrcW, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy
  );

  modport slave (
    input  RA1D, RA2D, RA3D, R3D_valid, RA1E, RA2E, WA3E, WA3M, WA3W,
           MemtoRegE, RegWriteM, RegWriteW, Mul_CtrlD, PCWrPendingF, PCSrcW, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy
  );
endinterface

// File: rtl/hazard_unit_mul_stall_seq.sv
// Multi-cycle multiply sequencer: tracks a multiply in Execute and holds the
// front of the pipe for MUL_LAT-1 cycles.
module mul_stall_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic mul_ctrl_d_i,
  input  logic stall_e_i,
  input  logic flush_e_i,
  output logic mulstall_o,
  output logic mul_busy_o
);

  localparam logic [3:0] LAST = 4'(MUL_LAT - 1);

  logic       mul_e_q, mul_e_d;
  logic [3:0] cnt_q, cnt_d;
  mul_state_e state_q, state_d;
  logic       mulstall;

  // State tracks the next cycle's mulstall, so MulBusy lines up with the stalls.
  always_comb begin
    mulstall = mul_e_q && (cnt_q < LAST);

    mul_e_d = mul_e_q;
    if (flush_e_i)
      mul_e_d = 1'b0;
    else if (!stall_e_i)
      mul_e_d = mul_ctrl_d_i;

    cnt_d = cnt_q;
    if (mulstall)
      cnt_d = cnt_q + 4'd1;
    else if (mul_e_q)
      cnt_d = 4'd0;

    state_d = (mul_e_d && (cnt_d < LAST)) ? BUSY : IDLE;
  end

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      mul_e_q <= 1'b0;
      cnt_q   <= 4'd0;
      state_q <= IDLE;
    end else begin
      mul_e_q <= mul_e_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign mulstall_o = mulstall;
  assign mul_busy_o = (state_q == BUSY);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard resolver: forwarding, load-use and multiply stalls, flushes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/load-use counters.
module hazard_unit #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
  output logic [31:0] LdUseCnt
`endif
);
  import hazard_pkg::*;

  logic ldstall;
  logic mulstall;
  logic mul_busy;
  logic stall_d, stall_e, flush_d, flush_e;

  assign ldstall = hz.MemtoRegE &&
                   ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E) ||
                    (hz.R3D_valid && (hz.RA3D == hz.WA3E)));

  assign stall_d = ldstall || mulstall;
  assign stall_e = mulstall;
  assign flush_d = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE;
  // A held multiply keeps E occupied, so a pending flush waits until E advances.
  assign flush_e = (ldstall || hz.BranchTakenE) && !mulstall;

  mul_stall_seq #(.MUL_LAT(MUL_LAT)) u_mul_seq (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .mul_ctrl_d_i (hz.Mul_CtrlD),
    .stall_e_i    (stall_e),
    .flush_e_i    (flush_e),
    .mulstall_o   (mulstall),
    .mul_busy_o   (mul_busy)
  );

  assign hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  assign hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W);
  assign hz.StallF    = ldstall || hz.PCWrPendingF || mulstall;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.FlushM    = mulstall;
  assign hz.MulBusy   = mul_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, lduse_cnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      lduse_cnt_q <= 32'd0;
    end else begin
      if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((flush_d || flush_e) && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (ldstall && (lduse_cnt_q != 32'hFFFF_FFFF))
        lduse_cnt_q <= lduse_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign LdUseCnt = lduse_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: two instances (MUL_LAT=3 and MUL_LAT=1) share stimulus.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] RA1D, RA2D, RA3D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       R3D_valid, MemtoRegE, RegWriteM, RegWriteW;
  logic       Mul_CtrlD, PCWrPendingF, PCSrcW, BranchTakenE;

  hazard_if h3 ();
  hazard_if h1 ();

  assign h3.RA1D = RA1D;  assign h1.RA1D = RA1D;
  assign h3.RA2D = RA2D;  assign h1.RA2D = RA2D;
  assign h3.RA3D = RA3D;  assign h1.RA3D = RA3D;
  assign h3.R3D_valid = R3D_valid;  assign h1.R3D_valid = R3D_valid;
  assign h3.RA1E = RA1E;  assign h1.RA1E = RA1E;
  assign h3.RA2E = RA2E;  assign h1.RA2E = RA2E;
  assign h3.WA3E = WA3E;  assign h1.WA3E = WA3E;
  assign h3.WA3M = WA3M;  assign h1.WA3M = WA3M;
  assign h3.WA3W = WA3W;  assign h1.WA3W = WA3W;
  assign h3.MemtoRegE = MemtoRegE;  assign h1.MemtoRegE = MemtoRegE;
  assign h3.RegWriteM = RegWriteM;  assign h1.RegWriteM = RegWriteM;
  assign h3.RegWriteW = RegWriteW;  assign h1.RegWriteW = RegWriteW;
  assign h3.Mul_CtrlD = Mul_CtrlD;  assign h1.Mul_CtrlD = Mul_CtrlD;
  assign h3.PCWrPendingF = PCWrPendingF;  assign h1.PCWrPendingF = PCWrPendingF;
  assign h3.PCSrcW = PCSrcW;  assign h1.PCSrcW = PCSrcW;
  assign h3.BranchTakenE = BranchTakenE;  assign h1.BranchTakenE = BranchTakenE;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt3, flush_cnt3, lduse_cnt3;
  logic [31:0] stall_cnt1, flush_cnt1, lduse_cnt1;
`endif

  hazard_unit #(.MUL_LAT(3)) dut3 (
    .sys_clk   (clk),
    .sys_rst_n (rst),
    .hz        (h3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt  (stall_cnt3),
    .FlushCnt  (flush_cnt3),
    .LdUseCnt  (lduse_cnt3)
`endif
  );

  hazard_unit #(.MUL_LAT(1)) dut1 (
    .sys_clk   (clk),
    .sys_rst_n (rst),
    .hz        (h1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt  (stall_cnt1),
    .FlushCnt  (flush_cnt1),
    .LdUseCnt  (lduse_cnt1)
`endif
  );

  // Packed view: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy}
  logic [10:0] obs3, obs1;
  assign obs3 = {h3.ForwardAE, h3.ForwardBE, h3.StallF, h3.StallD, h3.StallE,
                 h3.FlushD, h3.FlushE, h3.FlushM, h3.MulBusy};
  assign obs1 = {h1.ForwardAE, h1.ForwardBE, h1.StallF, h1.StallD, h1.StallE,
                 h1.FlushD, h1.FlushE, h1.FlushM, h1.MulBusy};

  localparam logic [10:0] NONE  = 11'h000;
  localparam logic [10:0] FAE_M = 11'h400;
  localparam logic [10:0] FAE_W = 11'h200;
  localparam logic [10:0] FBE_M = 11'h100;
  localparam logic [10:0] FBE_W = 11'h080;
  localparam logic [10:0] SF    = 11'h040;
  localparam logic [10:0] SD    = 11'h020;
  localparam logic [10:0] SE    = 11'h010;
  localparam logic [10:0] FD    = 11'h008;
  localparam logic [10:0] FE    = 11'h004;
  localparam logic [10:0] FM    = 11'h002;
  localparam logic [10:0] MB    = 11'h001;
  localparam logic [10:0] MS    = SF | SD | SE | FM | MB;
  localparam logic [10:0] LDU   = SF | SD | FE;

  typedef struct {
    string       name;
    logic [10:0] e3;
    logic [10:0] e1;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic clear_inputs();
    RA1D = 4'd0; RA2D = 4'd0; RA3D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    R3D_valid = 1'b0; MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    Mul_CtrlD = 1'b0; PCWrPendingF = 1'b0; PCSrcW = 1'b0; BranchTakenE = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      if (i == 1) rst = 1'b0;
      sb.push_back('{(i == 0) ? "reset_held" : "reset_released", NONE, NONE});
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
                 sb.push_back('{"fwd_a_mem", FAE_M, FAE_M}); end
        1: begin RegWriteW = 1; WA3W = 3; WA3M = 3; RA1E = 3;
                 sb.push_back('{"fwd_a_wb", FAE_W, FAE_W}); end
        2: begin RegWriteM = 1; WA3M = 15; RegWriteW = 1; WA3W = 15; RA1E = 15; RA2E = 15;
                 sb.push_back('{"fwd_pc_blocked", NONE, NONE}); end
        3: begin RegWriteW = 1; WA3W = 7; WA3M = 7; RA2E = 7;
                 sb.push_back('{"fwd_b_wb", FBE_W, FBE_W}); end
        4: begin RegWriteM = 1; WA3M = 4; RegWriteW = 1; WA3W = 4; RA1E = 4; RA2E = 4;
                 sb.push_back('{"fwd_mem_beats_wb", FAE_M | FBE_M, FAE_M | FBE_M}); end
        default: begin RegWriteM = 1; WA3M = 2; RegWriteW = 1; WA3W = 9; RA1E = 9; RA2E = 9;
                 sb.push_back('{"fwd_wb_only_match", FAE_W | FBE_W, FAE_W | FBE_W}); end
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin MemtoRegE = 1; WA3E = 5; RA2D = 5; sb.push_back('{"lduse_ra2", LDU, LDU}); end
        1: sb.push_back('{"lduse_clear", NONE, NONE});
        2: begin MemtoRegE = 1; WA3E = 5; RA3D = 5; R3D_valid = 0;
                 sb.push_back('{"lduse_ra3_dead", NONE, NONE}); end
        3: begin MemtoRegE = 1; WA3E = 5; RA3D = 5; R3D_valid = 1;
                 sb.push_back('{"lduse_ra3_live", LDU, LDU}); end
        4: begin WA3E = 5; RA1D = 5; sb.push_back('{"lduse_no_load", NONE, NONE}); end
        default: begin MemtoRegE = 1; WA3E = 5; RA1D = 5; sb.push_back('{"lduse_ra1", LDU, LDU}); end
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  task automatic test_multiply();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin Mul_CtrlD = 1; sb.push_back('{"mul_issue", NONE, NONE}); end
        1: sb.push_back('{"mul_stall1", MS, NONE});
        2: sb.push_back('{"mul_stall2", MS, NONE});
        3: sb.push_back('{"mul_done", NONE, NONE});
        default: sb.push_back('{"mul_idle", NONE, NONE});
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0: begin BranchTakenE = 1; sb.push_back('{"br_taken", FD | FE, FD | FE}); end
        1: begin PCWrPendingF = 1; sb.push_back('{"pc_pending", SF | FD, SF | FD}); end
        2: begin PCSrcW = 1; sb.push_back('{"pc_src_w", FD, FD}); end
        3: begin Mul_CtrlD = 1; sb.push_back('{"br_mul_issue", NONE, NONE}); end
        4: begin BranchTakenE = 1; sb.push_back('{"br_during_mul1", MS | FD, FD | FE}); end
        5: begin BranchTakenE = 1; sb.push_back('{"br_during_mul2", MS | FD, FD | FE}); end
        6: begin BranchTakenE = 1; sb.push_back('{"br_after_mul", FD | FE, FD | FE}); end
        default: sb.push_back('{"br_idle", NONE, NONE});
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_inputs();
      Mul_CtrlD = (i <= 3);
      case (i)
        0: sb.push_back('{"b2b_issue1", NONE, NONE});
        1: sb.push_back('{"b2b_m1_stall1", MS, NONE});
        2: sb.push_back('{"b2b_m1_stall2", MS, NONE});
        3: sb.push_back('{"b2b_issue2", NONE, NONE});
        4: sb.push_back('{"b2b_m2_stall1", MS, NONE});
        5: sb.push_back('{"b2b_m2_stall2", MS, NONE});
        default: sb.push_back('{"b2b_idle", NONE, NONE});
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

  // Reset is raised mid-cycle in the first BUSY cycle to show the async drop.
  task automatic test_reset_mid_mul();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) #1;
      else @(negedge clk);
      clear_inputs();
      case (i)
        0: begin Mul_CtrlD = 1; sb.push_back('{"rst_mul_issue", NONE, NONE}); end
        1: sb.push_back('{"rst_mul_busy", MS, NONE});
        2: begin rst = 1'b1; sb.push_back('{"rst_async_drop", NONE, NONE}); end
        3: begin rst = 1'b0; sb.push_back('{"rst_released", NONE, NONE}); end
        default: sb.push_back('{"rst_idle_after", NONE, NONE});
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_inputs();
      case (i)
        0, 4: begin Mul_CtrlD = 1; sb.push_back('{"perf_mul_issue", NONE, NONE}); end
        1, 2, 5, 6: sb.push_back('{"perf_mul_stall", MS, NONE});
        8: begin MemtoRegE = 1; WA3E = 6; RA1D = 6; sb.push_back('{"perf_lduse", LDU, LDU}); end
        default: sb.push_back('{"perf_idle", NONE, NONE});
      endcase
      #1;
      e = sb.pop_front();
      checks += 2;
      if (obs3 !== e.e3) begin errors++; $display("FAIL %s lat3: got %h want %h", e.name, obs3, e.e3); end
      if (obs1 !== e.e1) begin errors++; $display("FAIL %s lat1: got %h want %h", e.name, obs1, e.e1); end
      $display("txn %s lat3=%h lat1=%h", e.name, obs3, obs1);
    end
    checks += 6;
    if (stall_cnt3 !== 32'd5) begin errors++; $display("FAIL stall_cnt lat3: got %0d want 5", stall_cnt3); end
    if (lduse_cnt3 !== 32'd1) begin errors++; $display("FAIL lduse_cnt lat3: got %0d want 1", lduse_cnt3); end
    if (flush_cnt3 !== 32'd1) begin errors++; $display("FAIL flush_cnt lat3: got %0d want 1", flush_cnt3); end
    if (stall_cnt1 !== 32'd1) begin errors++; $display("FAIL stall_cnt lat1: got %0d want 1", stall_cnt1); end
    if (lduse_cnt1 !== 32'd1) begin errors++; $display("FAIL lduse_cnt lat1: got %0d want 1", lduse_cnt1); end
    if (flush_cnt1 !== 32'd1) begin errors++; $display("FAIL flush_cnt lat1: got %0d want 1", flush_cnt1); end
    $display("txn perf_counters lat3=%0d/%0d/%0d lat1=%0d/%0d/%0d",
             stall_cnt3, flush_cnt3, lduse_cnt3, stall_cnt1, flush_cnt1, lduse_cnt1);
  endtask
`endif

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_multiply();
    test_branch();
    test_back_to_back();
    test_reset_mid_mul();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
